// File: rtl/ldpc_pkg.sv
// ldpc_pkg: parameters and types shared by the LDPC check-node blocks
// (min_sum_tree_20 produces compressed records, cn_msg_expander consumes
// them).
//   DW      : magnitude width of one message
//   DEG_MAX : largest check-node row degree
//   IW      : width of edge-index and degree fields
//   cn_rec_t: compressed check-node record layout, MSB first
//             {min1, min2, idx, signs, deg}
//   cn_state_t: expander engine state
package ldpc_pkg;

  localparam int DW      = 5;
  localparam int DEG_MAX = 20;
  localparam int IW      = 5;

  typedef struct packed {
    logic [DW-1:0]      min1;
    logic [DW-1:0]      min2;
    logic [IW-1:0]      idx;
    logic [DEG_MAX-1:0] signs;
    logic [IW-1:0]      deg;
  } cn_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } cn_state_t;

endpackage

// File: rtl/cn_msg_sel.sv
// cn_msg_sel: combinational per-edge c2v message generator.
// Ports:
//   i_min1, i_min2 : smallest / second-smallest v2c magnitude
//   i_idx          : edge position of min1
//   i_signs        : v2c sign bits, bit i = edge i
//   i_deg          : row degree (sign bits at or above it are ignored)
//   i_edge         : edge being emitted
//   o_sign         : c2v sign, 1 = negative
//   o_mag          : c2v magnitude after offset correction, floored at 0
module cn_msg_sel
  import ldpc_pkg::*;
#(
  parameter int DW      = ldpc_pkg::DW,
  parameter int DEG_MAX = ldpc_pkg::DEG_MAX,
  parameter int IW      = ldpc_pkg::IW,
  parameter int OFFSET  = 0
) (
  input  logic [DW-1:0]      i_min1,
  input  logic [DW-1:0]      i_min2,
  input  logic [IW-1:0]      i_idx,
  input  logic [DEG_MAX-1:0] i_signs,
  input  logic [IW-1:0]      i_deg,
  input  logic [IW-1:0]      i_edge,
  output logic               o_sign,
  output logic [DW-1:0]      o_mag
);

  localparam int unsigned OFF = OFFSET;

  logic [DEG_MAX-1:0] w_live;
  logic               w_parity;
  logic [DW-1:0]      w_m;

  // Only edges below the row degree contribute to the total sign.
  for (genvar gi = 0; gi < DEG_MAX; gi++) begin : g_live
    assign w_live[gi] = i_signs[gi] & (IW'(gi) < i_deg);
  end

  assign w_parity = ^w_live;

  // The min1 edge itself receives min2; an out-of-range idx never matches.
  assign w_m = (i_edge == i_idx) ? i_min2 : i_min1;

  // When w_m > OFF the offset fits in DW bits, so the truncation is exact.
  assign o_mag  = (32'(w_m) > OFF) ? (w_m - DW'(OFF)) : '0;
  assign o_sign = w_parity ^ i_signs[i_edge];

endmodule

// File: rtl/cn_msg_expander.sv
// cn_msg_expander: expands one compressed check-node record into deg
// serial c2v beats (edge 0..deg-1), with one active and one pending
// record register so records stream without bubbles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : record handshake; in_ready = pending slot free
//   in_min1/in_min2/in_idx/in_signs/in_deg : compressed record fields
//   out_valid/out_ready : beat handshake
//   out_sign/out_mag/out_edge/out_last     : current beat
//   deg_err             : one-cycle pulse after accepting an illegal in_deg
module cn_msg_expander
  import ldpc_pkg::*;
#(
  parameter int DW      = ldpc_pkg::DW,
  parameter int DEG_MAX = ldpc_pkg::DEG_MAX,
  parameter int IW      = ldpc_pkg::IW,
  parameter int OFFSET  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_min1,
  input  logic [DW-1:0]      in_min2,
  input  logic [IW-1:0]      in_idx,
  input  logic [DEG_MAX-1:0] in_signs,
  input  logic [IW-1:0]      in_deg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [DW-1:0]      out_mag,
  output logic [IW-1:0]      out_edge,
  output logic               out_last,
  output logic               deg_err
);

  // Same field order as ldpc_pkg::cn_rec_t, sized by this instance.
  typedef struct packed {
    logic [DW-1:0]      min1;
    logic [DW-1:0]      min2;
    logic [IW-1:0]      idx;
    logic [DEG_MAX-1:0] signs;
    logic [IW-1:0]      deg;
  } rec_t;

  cn_state_t     r_state;
  rec_t          r_act;
  rec_t          r_pend;
  logic          r_pend_full;
  logic [IW-1:0] r_edge;
  logic          r_deg_err;

  rec_t w_in_rec;
  logic w_accept;
  logic w_legal;
  logic w_load_new;
  logic w_fire;
  logic w_last_beat;

  assign w_in_rec    = '{min1: in_min1, min2: in_min2, idx: in_idx,
                         signs: in_signs, deg: in_deg};
  assign w_accept    = in_valid & in_ready;
  assign w_legal     = (in_deg != '0) && (32'(in_deg) <= DEG_MAX);
  assign w_load_new  = w_accept & w_legal;
  assign w_fire      = out_valid & out_ready;
  assign w_last_beat = (r_edge == (r_act.deg - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_act       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_edge      <= '0;
      r_deg_err   <= 1'b0;
    end else begin
      // Illegal records are swallowed: flag them and touch nothing else.
      r_deg_err <= w_accept & ~w_legal;
      case (r_state)
        ST_IDLE: begin
          if (w_load_new) begin
            r_act   <= w_in_rec;
            r_edge  <= '0;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_fire && w_last_beat) begin
            // in_ready is low while pending is full, so no new record can
            // arrive in the same cycle the pending one moves up.
            if (r_pend_full) begin
              r_act       <= r_pend;
              r_edge      <= '0;
              r_pend_full <= 1'b0;
            end else if (w_load_new) begin
              // A record arriving exactly on the last beat goes straight
              // to active; parking it in pending would strand it in IDLE.
              r_act  <= w_in_rec;
              r_edge <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            if (w_fire) begin
              r_edge <= r_edge + 1'b1;
            end
            if (w_load_new) begin
              r_pend      <= w_in_rec;
              r_pend_full <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  cn_msg_sel #(
    .DW      (DW),
    .DEG_MAX (DEG_MAX),
    .IW      (IW),
    .OFFSET  (OFFSET)
  ) u_sel (
    .i_min1  (r_act.min1),
    .i_min2  (r_act.min2),
    .i_idx   (r_act.idx),
    .i_signs (r_act.signs),
    .i_deg   (r_act.deg),
    .i_edge  (r_edge),
    .o_sign  (out_sign),
    .o_mag   (out_mag)
  );

  assign in_ready  = ~r_pend_full;
  assign out_valid = (r_state == ST_EMIT);
  assign out_edge  = r_edge;
  assign out_last  = out_valid & w_last_beat;
  assign deg_err   = r_deg_err;

endmodule

// File: tb/tb_cn_msg_expander.sv
// tb_cn_msg_expander: scoreboard bench for cn_msg_expander. Two instances
// share all stimulus: u0 with OFFSET=0 and u2 with OFFSET=2. Expected beats
// are pushed when a record is accepted and popped as beats are consumed.
module tb_cn_msg_expander;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic [4:0]  in_min1, in_min2, in_idx, in_deg;
  logic [19:0] in_signs;
  logic        out_ready;

  logic        in_ready_0, out_valid_0, out_sign_0, out_last_0, deg_err_0;
  logic [4:0]  out_mag_0, out_edge_0;
  logic        in_ready_2, out_valid_2, out_sign_2, out_last_2, deg_err_2;
  logic [4:0]  out_mag_2, out_edge_2;

  always #5 clk = ~clk;

  cn_msg_expander #(.DW(5), .DEG_MAX(20), .IW(5), .OFFSET(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_0),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx),
    .in_signs(in_signs), .in_deg(in_deg), .out_valid(out_valid_0),
    .out_ready(out_ready), .out_sign(out_sign_0), .out_mag(out_mag_0),
    .out_edge(out_edge_0), .out_last(out_last_0), .deg_err(deg_err_0)
  );

  cn_msg_expander #(.DW(5), .DEG_MAX(20), .IW(5), .OFFSET(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx),
    .in_signs(in_signs), .in_deg(in_deg), .out_valid(out_valid_2),
    .out_ready(out_ready), .out_sign(out_sign_2), .out_mag(out_mag_2),
    .out_edge(out_edge_2), .out_last(out_last_2), .deg_err(deg_err_2)
  );

  typedef struct {
    logic       s;
    logic [4:0] m;
    logic [4:0] e;
    logic       l;
  } beat_t;

  beat_t q0[$];
  beat_t q2[$];
  int n_tests = 0;
  int n_fail = 0;
  int err_exp = 0;
  int err_seen0 = 0;
  int err_seen2 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour for one accepted record, for both offsets.
  function automatic void model(input logic [4:0] mn1, input logic [4:0] mn2,
                                input logic [4:0] ix, input logic [19:0] sg,
                                input logic [4:0] dg);
    logic  s;
    int    m;
    beat_t b;
    if (dg == 0 || dg > 20) begin
      err_exp++;
      return;
    end
    s = 1'b0;
    for (int i = 0; i < int'(dg); i++) s = s ^ sg[i];
    for (int e = 0; e < int'(dg); e++) begin
      m   = (e == int'(ix)) ? int'(mn2) : int'(mn1);
      b.e = 5'(e);
      b.l = (e == int'(dg) - 1);
      b.s = s ^ sg[e];
      b.m = 5'(m);
      q0.push_back(b);
      b.m = (m > 2) ? 5'(m - 2) : 5'd0;
      q2.push_back(b);
    end
  endfunction

  // Call at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [4:0] mn1, input logic [4:0] mn2,
                      input logic [4:0] ix, input logic [19:0] sg,
                      input logic [4:0] dg);
    bit ok;
    in_min1 = mn1; in_min2 = mn2; in_idx = ix; in_signs = sg; in_deg = dg;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (in_ready_0) begin
        model(mn1, mn2, ix, sg, dg);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      check_eq("send_timeout", 32'(ok), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && !out_valid_0) done = 1'b1;
    end
    check_eq(tag, 32'(done), 1);
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer: every handshaken beat is compared against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (deg_err_0) err_seen0++;
      if (deg_err_2) err_seen2++;
      if (out_valid_0 && out_ready) begin
        if (q0.size() == 0) check_eq("unexpected_beat0", 32'(out_valid_0), 0);
        else begin
          beat_t b;
          b = q0.pop_front();
          check_eq($sformatf("edge0_e%0d", b.e), 32'(out_edge_0), 32'(b.e));
          check_eq($sformatf("mag0_e%0d", b.e),  32'(out_mag_0),  32'(b.m));
          check_eq($sformatf("sign0_e%0d", b.e), 32'(out_sign_0), 32'(b.s));
          check_eq($sformatf("last0_e%0d", b.e), 32'(out_last_0), 32'(b.l));
        end
      end
      if (out_valid_2 && out_ready) begin
        if (q2.size() == 0) check_eq("unexpected_beat2", 32'(out_valid_2), 0);
        else begin
          beat_t b;
          b = q2.pop_front();
          check_eq($sformatf("edge2_e%0d", b.e), 32'(out_edge_2), 32'(b.e));
          check_eq($sformatf("mag2_e%0d", b.e),  32'(out_mag_2),  32'(b.m));
          check_eq($sformatf("sign2_e%0d", b.e), 32'(out_sign_2), 32'(b.s));
          check_eq($sformatf("last2_e%0d", b.e), 32'(out_last_2), 32'(b.l));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    in_valid = 1'b0; in_min1 = '0; in_min2 = '0; in_idx = '0;
    in_signs = '0; in_deg = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid_0), 0);
    check_eq("rst_in_ready",  32'(in_ready_0), 1);
    check_eq("rst_deg_err",   32'(deg_err_0), 0);
    check_eq("rst_out_last",  32'(out_last_0), 0);
    check_eq("rst_out_sign",  32'(out_sign_0), 0);
    check_eq("rst_out_mag",   32'(out_mag_0), 0);
    check_eq("rst_out_edge",  32'(out_edge_0), 0);
    check_eq("rst_out_mag2",  32'(out_mag_2), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 19 beats, min2 on edge 17 only, last on edge 18.
    send(5'd1, 5'd2, 5'd17, 20'h0, 5'd19);
    wait_drain("drain_t1");

    // Sign sequence 1,0,1,0; mags 6,3,3,3; first beat one cycle after accept.
    send(5'd3, 5'd6, 5'd0, 20'h00005, 5'd4);
    @(negedge clk);
    check_eq("lat_valid", 32'(out_valid_0), 1);
    check_eq("lat_edge",  32'(out_edge_0), 0);
    wait_drain("drain_t2");

    // Offset saturation on u2: zeros except edge 3 (9-2=7).
    send(5'd1, 5'd9, 5'd3, 20'hABCDE, 5'd20);
    wait_drain("drain_t3");

    // idx beyond degree, sign bits above degree set.
    send(5'd7, 5'd2, 5'd25, 20'hFFFC7, 5'd6);
    wait_drain("drain_t4");

    // Back-to-back records.
    send(5'd5, 5'd8, 5'd1, 20'h00003, 5'd5);
    send(5'd2, 5'd4, 5'd2, 20'h00006, 5'd3);
    @(negedge clk);
    check_eq("pend_full_ready", 32'(in_ready_0), 0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_valid_0 && out_ready && out_last_0) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("b2b_found_last", 32'(found), 1);
    @(negedge clk);
    check_eq("b2b_valid", 32'(out_valid_0), 1);
    check_eq("b2b_edge0", 32'(out_edge_0), 0);
    @(posedge clk); #1;
    wait_drain("drain_b2b");

    // Stall at edge 7: S=1, signs[7]=1 -> sign 0; edge 7 == idx -> mag 9.
    send(5'd4, 5'd9, 5'd7, 20'h000A1, 5'd12);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (out_valid_0 && out_edge_0 == 5'd6) found = 1'b1;
    end
    check_eq("stall_found_e6", 32'(found), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(out_valid_0), 1);
      check_eq("stall_edge",  32'(out_edge_0), 7);
      check_eq("stall_mag",   32'(out_mag_0), 9);
      check_eq("stall_sign",  32'(out_sign_0), 0);
      check_eq("stall_last",  32'(out_last_0), 0);
      check_eq("stall_mag2",  32'(out_mag_2), 7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("after_stall_edge", 32'(out_edge_0), 8);
    @(posedge clk); #1;
    wait_drain("drain_stall");

    // Illegal degrees: accepted, no beats, one deg_err pulse each.
    send(5'd1, 5'd2, 5'd0, 20'h0, 5'd0);
    @(negedge clk);
    check_eq("deg0_err",   32'(deg_err_0), 1);
    check_eq("deg0_valid", 32'(out_valid_0), 0);
    @(posedge clk); #1;
    send(5'd1, 5'd2, 5'd0, 20'h0, 5'd21);
    @(negedge clk);
    check_eq("deg21_err", 32'(deg_err_0), 1);
    @(negedge clk);
    check_eq("deg21_err_clear", 32'(deg_err_0), 0);
    check_eq("deg21_valid",     32'(out_valid_0), 0);
    @(posedge clk); #1;

    // Reset mid-record with a pending record.
    send(5'd3, 5'd5, 5'd10, 20'h01234, 5'd15);
    send(5'd6, 5'd1, 5'd0, 20'h0000F, 5'd4);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (out_valid_0 && out_edge_0 == 5'd10) found = 1'b1;
    end
    check_eq("rst_found_e10", 32'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid",    32'(out_valid_0), 0);
    check_eq("midrst_in_ready", 32'(in_ready_0), 1);
    check_eq("midrst_edge",     32'(out_edge_0), 0);
    check_eq("midrst_mag",      32'(out_mag_0), 0);
    check_eq("midrst_last",     32'(out_last_0), 0);
    q0.delete();
    q2.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("postrst_idle", 32'(out_valid_0), 0);
    end
    @(posedge clk); #1;
    send(5'd2, 5'd3, 5'd1, 20'h00002, 5'd3);
    wait_drain("drain_postrst");

    check_eq("err_pulses0", 32'(err_seen0), 32'(err_exp));
    check_eq("err_pulses2", 32'(err_seen2), 32'(err_exp));
    check_eq("q0_left", 32'(q0.size()), 0);
    check_eq("q2_left", 32'(q2.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
